// File: rtl/dram_ctrl_pkg.sv
// Shared types and default timing for the FPM DRAM controller.
//   state_e : controller FSM states
//   DEF_*   : default geometry and timing, in CLK cycles
//   max_u   : helper used to size the multiplexed address bus
package dram_ctrl_pkg;

    localparam int unsigned DEF_ROW_BITS     = 11;
    localparam int unsigned DEF_COL_BITS     = 11;
    localparam int unsigned DEF_RCD_CYC      = 1;
    localparam int unsigned DEF_CAS_ACK_CYC  = 1;
    localparam int unsigned DEF_RP_CYC       = 2;
    localparam int unsigned DEF_REF_RAS_CYC  = 3;
    localparam int unsigned DEF_REF_INTERVAL = 240;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROW     = 3'd1,
        ST_COL     = 3'd2,
        ST_ACK     = 3'd3,
        ST_REF_CAS = 3'd4,
        ST_REF_RAS = 3'd5,
        ST_PRE     = 3'd6
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer with a sticky request flag.
//   clk_i      : clock
//   rst_i      : asynchronous reset, active-high
//   clr_i      : clears the pending request (refresh has been started)
//   ref_pend_o : refresh requested and not yet started
module dram_refresh_timer
    import dram_ctrl_pkg::*;
#(
    parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic ref_pend_o
);

    localparam int unsigned CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pend_q;
    logic             pend_d;
    logic             wrap_c;

    // Count 0..REF_INTERVAL-1; a wrap raises the request, a second wrap is absorbed.
    always_comb begin
        wrap_c = (cnt_q == CNT_W'(REF_INTERVAL - 1));
        cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end
        if (wrap_c) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pend_o = pend_q;

endmodule

// File: rtl/dram_controller.sv
// FPM DRAM sequencer for the 68000 bus with CAS-before-RAS refresh.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   as_n_i              : address strobe (active-low)
//   uds_n_i, lds_n_i    : upper/lower data strobes (active-low)
//   rw_i                : 1 = read, 0 = write
//   dram_n_i            : DRAM region select (active-low)
//   addr_i              : CPU word address, {row, col}
//   ma_o                : multiplexed DRAM address
//   ras_n_o             : row strobe (active-low)
//   cas_u_n_o/cas_l_n_o : column strobes for D15-D8 / D7-D0 (active-low)
//   we_n_o              : write enable (active-low)
//   dtack_dram_n_o      : transfer acknowledge (active-low)
module dram_controller
    import dram_ctrl_pkg::*;
#(
    parameter int unsigned ROW_BITS     = DEF_ROW_BITS,
    parameter int unsigned COL_BITS     = DEF_COL_BITS,
    parameter int unsigned RCD_CYC      = DEF_RCD_CYC,
    parameter int unsigned CAS_ACK_CYC  = DEF_CAS_ACK_CYC,
    parameter int unsigned RP_CYC       = DEF_RP_CYC,
    parameter int unsigned REF_RAS_CYC  = DEF_REF_RAS_CYC,
    parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    as_n_i,
    input  logic                                    uds_n_i,
    input  logic                                    lds_n_i,
    input  logic                                    rw_i,
    input  logic                                    dram_n_i,
    input  logic [ROW_BITS+COL_BITS-1:0]            addr_i,
    output logic [max_u(ROW_BITS, COL_BITS)-1:0]    ma_o,
    output logic                                    ras_n_o,
    output logic                                    cas_u_n_o,
    output logic                                    cas_l_n_o,
    output logic                                    we_n_o,
    output logic                                    dtack_dram_n_o
);

    localparam int unsigned MA_W    = max_u(ROW_BITS, COL_BITS);
    localparam int unsigned STB_MAX = max_u(max_u(RCD_CYC, CAS_ACK_CYC), max_u(RP_CYC, REF_RAS_CYC));
    localparam int unsigned CNT_W   = (STB_MAX > 1) ? $clog2(STB_MAX) : 1;

    // Registered bus inputs (raw pin levels)
    logic as_n_q, uds_n_q, lds_n_q, rw_q, dram_n_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MA_W-1:0]  ma_q, ma_d;
    logic             ras_n_q, ras_n_d;
    logic             cas_u_n_q, cas_u_n_d;
    logic             cas_l_n_q, cas_l_n_d;
    logic             we_n_q, we_n_d;
    logic             dtack_n_q, dtack_n_d;

    logic             ref_pend;
    logic             ref_clr_c;
    logic             access_c;
    logic             ds_any_c;
    logic [MA_W-1:0]  row_c;
    logic [MA_W-1:0]  col_c;

    dram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (ref_clr_c),
        .ref_pend_o (ref_pend)
    );

    assign row_c    = MA_W'(addr_i[ROW_BITS+COL_BITS-1:COL_BITS]);
    assign col_c    = MA_W'(addr_i[COL_BITS-1:0]);
    assign access_c = ~as_n_q & ~dram_n_q;
    assign ds_any_c = ~uds_n_q | ~lds_n_q;

    // Next state and next outputs. Strobes are decoded from the current state and
    // registered, so they trail the state by one CLK; every output is a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        ma_d      = ma_q;
        ras_n_d   = 1'b1;
        cas_u_n_d = 1'b1;
        cas_l_n_d = 1'b1;
        we_n_d    = 1'b1;
        dtack_n_d = 1'b1;
        ref_clr_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ma_d = row_c;
                if (ref_pend) begin
                    state_d   = ST_REF_CAS;
                    ref_clr_c = 1'b1;
                end else if (access_c) begin
                    state_d = ST_ROW;
                end
            end

            ST_ROW: begin
                if (as_n_q) begin
                    state_d = ST_PRE;
                end else begin
                    ras_n_d = 1'b0;
                    // Early write: WE is low from RAS onward, ahead of any CAS
                    we_n_d  = rw_q;
                    if (cnt_q == CNT_W'(RCD_CYC - 1)) begin
                        state_d = ST_COL;
                    end
                end
            end

            ST_COL: begin
                if (as_n_q) begin
                    state_d = ST_PRE;
                end else begin
                    ras_n_d = 1'b0;
                    we_n_d  = rw_q;
                    ma_d    = col_c;
                    if (ds_any_c) begin
                        cas_u_n_d = uds_n_q;
                        cas_l_n_d = lds_n_q;
                        if (cnt_q == CNT_W'(CAS_ACK_CYC - 1)) begin
                            state_d = ST_ACK;
                        end
                    end else begin
                        // Write data not yet valid: hold CAS off and restart the count
                        cnt_d = '0;
                    end
                end
            end

            ST_ACK: begin
                // Leaving only on AS high guarantees one DTACK per bus cycle
                if (as_n_q) begin
                    state_d = ST_PRE;
                end else begin
                    ras_n_d   = 1'b0;
                    we_n_d    = rw_q;
                    cas_u_n_d = cas_u_n_q;
                    cas_l_n_d = cas_l_n_q;
                    dtack_n_d = 1'b0;
                end
            end

            ST_REF_CAS: begin
                cas_u_n_d = 1'b0;
                cas_l_n_d = 1'b0;
                state_d   = ST_REF_RAS;
            end

            ST_REF_RAS: begin
                cas_u_n_d = 1'b0;
                cas_l_n_d = 1'b0;
                ras_n_d   = 1'b0;
                if (cnt_q == CNT_W'(REF_RAS_CYC - 1)) begin
                    state_d = ST_PRE;
                end
            end

            ST_PRE: begin
                ma_d = row_c;
                if (cnt_q == CNT_W'(RP_CYC - 1)) begin
                    // A waiting access goes straight to ROW; refresh still has priority
                    if (!ref_pend && access_c) begin
                        state_d = ST_ROW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe/precharge counter restarts on every state entry
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            as_n_q    <= 1'b1;
            uds_n_q   <= 1'b1;
            lds_n_q   <= 1'b1;
            rw_q      <= 1'b1;
            dram_n_q  <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ma_q      <= '0;
            ras_n_q   <= 1'b1;
            cas_u_n_q <= 1'b1;
            cas_l_n_q <= 1'b1;
            we_n_q    <= 1'b1;
            dtack_n_q <= 1'b1;
        end else begin
            as_n_q    <= as_n_i;
            uds_n_q   <= uds_n_i;
            lds_n_q   <= lds_n_i;
            rw_q      <= rw_i;
            dram_n_q  <= dram_n_i;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ma_q      <= ma_d;
            ras_n_q   <= ras_n_d;
            cas_u_n_q <= cas_u_n_d;
            cas_l_n_q <= cas_l_n_d;
            we_n_q    <= we_n_d;
            dtack_n_q <= dtack_n_d;
        end
    end

    assign ma_o           = ma_q;
    assign ras_n_o        = ras_n_q;
    assign cas_u_n_o      = cas_u_n_q;
    assign cas_l_n_o      = cas_l_n_q;
    assign we_n_o         = we_n_q;
    assign dtack_dram_n_o = dtack_n_q;

endmodule

// File: tb/tb_dram_controller.sv
// Directed bench for dram_controller: reset, read, byte write, refresh,
// refresh/access collision, abort, non-DRAM access and reset mid-cycle.
module tb_dram_controller;

    logic        clk;
    logic        rst;
    logic        as_n, uds_n, lds_n, rw, dram_n;
    logic [21:0] addr;
    logic [10:0] ma;
    logic        ras_n, cas_u_n, cas_l_n, we_n, dtack_n;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;

    dram_controller dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .as_n_i         (as_n),
        .uds_n_i        (uds_n),
        .lds_n_i        (lds_n),
        .rw_i           (rw),
        .dram_n_i       (dram_n),
        .addr_i         (addr),
        .ma_o           (ma),
        .ras_n_o        (ras_n),
        .cas_u_n_o      (cas_u_n),
        .cas_l_n_o      (cas_l_n),
        .we_n_o         (we_n),
        .dtack_dram_n_o (dtack_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_to(input int unsigned n);
        while (cyc < n) tick();
    endtask

    task automatic bus_idle();
        as_n   = 1'b1;
        uds_n  = 1'b1;
        lds_n  = 1'b1;
        rw     = 1'b1;
        dram_n = 1'b1;
    endtask

    // From reset release (cyc = 0): quiet for 241 edges, then CBR refresh shape
    task automatic refresh_after_reset(input string pfx);
        int unsigned lows = 0;
        while (cyc < 241) begin
            tick();
            if (!cas_u_n || !cas_l_n || !ras_n || !dtack_n) lows++;
        end
        check_eq({pfx, "_quiet"}, 32'(lows), 32'd0);
        tick(); // 242
        check_eq({pfx, "_cas_u_first"}, 32'(cas_u_n), 32'd0);
        check_eq({pfx, "_cas_l_first"}, 32'(cas_l_n), 32'd0);
        check_eq({pfx, "_ras_after_cas"}, 32'(ras_n), 32'd1);
        check_eq({pfx, "_we_high"}, 32'(we_n), 32'd1);
        tick(); // 243
        check_eq({pfx, "_ras_low1"}, 32'(ras_n), 32'd0);
        tick(); // 244
        tick(); // 245
        check_eq({pfx, "_ras_low3"}, 32'(ras_n), 32'd0);
        check_eq({pfx, "_cas_low3"}, 32'(cas_u_n), 32'd0);
        tick(); // 246
        check_eq({pfx, "_ras_rel"}, 32'(ras_n), 32'd1);
        check_eq({pfx, "_cas_rel"}, 32'(cas_l_n), 32'd1);
    endtask

    initial begin
        int unsigned bad;
        rst  = 1'b1;
        addr = '0;
        bus_idle();
        tick();
        tick();

        check_eq("rst_ras", 32'(ras_n), 32'd1);
        check_eq("rst_cas_u", 32'(cas_u_n), 32'd1);
        check_eq("rst_cas_l", 32'(cas_l_n), 32'd1);
        check_eq("rst_we", 32'(we_n), 32'd1);
        check_eq("rst_dtack", 32'(dtack_n), 32'd1);
        check_eq("rst_ma", 32'(ma), 32'd0);

        rst = 1'b0;
        cyc = 0;
        refresh_after_reset("ref1");

        // Word read at byte 0x012344 -> word 0x91A2: row 0x12, col 0x1A2
        wait_to(259);
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; dram_n = 1'b0;
        addr = 22'h0091A2;
        tick(); // 260: AS sampled
        check_eq("rd_dtack_e0", 32'(dtack_n), 32'd1);
        tick(); // 261
        check_eq("rd_ras_e1", 32'(ras_n), 32'd1);
        tick(); // 262
        check_eq("rd_ras_e2", 32'(ras_n), 32'd0);
        check_eq("rd_ma_row", 32'(ma), 32'h12);
        check_eq("rd_cas_u_e2", 32'(cas_u_n), 32'd1);
        tick(); // 263
        check_eq("rd_cas_u_e3", 32'(cas_u_n), 32'd0);
        check_eq("rd_cas_l_e3", 32'(cas_l_n), 32'd0);
        check_eq("rd_ma_col", 32'(ma), 32'h1A2);
        check_eq("rd_dtack_e3", 32'(dtack_n), 32'd1);
        tick(); // 264
        check_eq("rd_dtack_e4", 32'(dtack_n), 32'd0);
        check_eq("rd_we", 32'(we_n), 32'd1);
        tick(); // 265
        check_eq("rd_dtack_hold", 32'(dtack_n), 32'd0);
        bus_idle();
        tick(); // 266: AS high registered
        check_eq("rd_dtack_as_reg", 32'(dtack_n), 32'd0);
        tick(); // 267
        check_eq("rd_dtack_rel", 32'(dtack_n), 32'd1);
        check_eq("rd_ras_rel", 32'(ras_n), 32'd1);
        check_eq("rd_cas_rel", 32'(cas_u_n), 32'd1);

        // Byte write, LDS only, DS two cycles after AS; word 0x155555: row 0x2AA, col 0x555
        wait_to(279);
        as_n = 1'b0; rw = 1'b0; dram_n = 1'b0;
        addr = 22'h155555;
        tick(); // 280
        tick(); // 281
        lds_n = 1'b0;
        tick(); // 282
        check_eq("wr_ras", 32'(ras_n), 32'd0);
        check_eq("wr_we_early", 32'(we_n), 32'd0);
        check_eq("wr_cas_l_pre", 32'(cas_l_n), 32'd1);
        check_eq("wr_ma_row", 32'(ma), 32'h2AA);
        tick(); // 283
        check_eq("wr_cas_l", 32'(cas_l_n), 32'd0);
        check_eq("wr_cas_u", 32'(cas_u_n), 32'd1);
        check_eq("wr_ma_col", 32'(ma), 32'h555);
        check_eq("wr_dtack_e3", 32'(dtack_n), 32'd1);
        tick(); // 284
        check_eq("wr_dtack", 32'(dtack_n), 32'd0);
        check_eq("wr_we_ack", 32'(we_n), 32'd0);
        bus_idle();
        tick(); // 285
        tick(); // 286
        check_eq("wr_dtack_rel", 32'(dtack_n), 32'd1);
        check_eq("wr_we_rel", 32'(we_n), 32'd1);

        // Collision: AS sampled on edge 480, the same edge the refresh request sets
        wait_to(479);
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; dram_n = 1'b0;
        addr = 22'h000800;
        tick(); // 480
        tick(); // 481
        tick(); // 482
        check_eq("col_ref_cas", 32'(cas_u_n), 32'd0);
        check_eq("col_ref_ras_hi", 32'(ras_n), 32'd1);
        tick(); // 483
        check_eq("col_ref_ras", 32'(ras_n), 32'd0);
        wait_to(487);
        check_eq("col_pre_ras", 32'(ras_n), 32'd1);
        check_eq("col_pre_dtack", 32'(dtack_n), 32'd1);
        tick(); // 488
        check_eq("col_acc_ras", 32'(ras_n), 32'd0);
        check_eq("col_acc_ma_row", 32'(ma), 32'h1);
        tick(); // 489
        check_eq("col_acc_cas", 32'(cas_u_n), 32'd0);
        check_eq("col_acc_ma_col", 32'(ma), 32'h0);
        check_eq("col_dtack_e9", 32'(dtack_n), 32'd1);
        tick(); // 490 = 480 + 4 + 6
        check_eq("col_dtack_e10", 32'(dtack_n), 32'd0);
        bus_idle();
        tick();
        tick();
        check_eq("col_dtack_rel", 32'(dtack_n), 32'd1);

        // Abort: AS held for one sample only, so it is high while in ROW
        wait_to(509);
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; dram_n = 1'b0;
        addr = 22'h000123;
        tick(); // 510
        bus_idle();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!ras_n || !dtack_n || !cas_u_n) bad++;
        end
        check_eq("abort_no_strobe", 32'(bad), 32'd0);

        // Non-DRAM access (ROM): AS low with DRAM deselected
        wait_to(529);
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; dram_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!ras_n || !cas_u_n || !cas_l_n || !we_n || !dtack_n) bad++;
        end
        check_eq("rom_no_strobe", 32'(bad), 32'd0);
        bus_idle();

        // Reset asserted mid-ACK of a write, between clock edges
        wait_to(559);
        as_n = 1'b0; lds_n = 1'b0; uds_n = 1'b0; rw = 1'b0; dram_n = 1'b0;
        addr = 22'h000456;
        wait_to(564);
        check_eq("mid_ack_dtack", 32'(dtack_n), 32'd0);
        check_eq("mid_ack_we", 32'(we_n), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ras", 32'(ras_n), 32'd1);
        check_eq("arst_cas_u", 32'(cas_u_n), 32'd1);
        check_eq("arst_cas_l", 32'(cas_l_n), 32'd1);
        check_eq("arst_we", 32'(we_n), 32'd1);
        check_eq("arst_dtack", 32'(dtack_n), 32'd1);
        check_eq("arst_ma", 32'(ma), 32'd0);
        bus_idle();
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        refresh_after_reset("ref2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
